// File: rtl/huffman_stream_decoder.sv
// Streaming decoder for a fixed 14-symbol prefix code: MSB-first input words are
// packed into a bit buffer and one symbol per cycle is emitted through a registered output.
module huffman_stream_decoder #(
  parameter int IN_W  = 8,
  parameter int BUF_W = 2 * IN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  output logic [3:0]                 out_sym,
  output logic [2:0]                 out_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(BUF_W+1)-1:0] buf_level,
  output logic [15:0]                sym_count,
  output logic                       done,
  output logic                       trunc_err,
  output logic [1:0]                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds valid and its payload stable until that edge.

  localparam int LW = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [LW-1:0]     level_q, level_d;
  logic              out_valid_q;
  logic [3:0]        out_sym_q;
  logic [2:0]        out_len_q;
  logic [15:0]       count_q;
  logic              trunc_q;
  logic              fresh_q;

  logic [5:0]        window;
  logic [3:0]        dec_sym;
  logic [2:0]        dec_len;
  logic              slot_free;
  logic              hs;
  logic              accept;
  logic              dec_ok;
  logic              discard;
  logic [BUF_W-1:0]  shifted;
  logic [BUF_W-1:0]  word_al;
  logic [LW-1:0]     lvl_after;

  // Buffer is head-aligned at the MSB; bits below level_q are always zero, so a
  // short tail decodes as if zero-padded.
  assign window = buf_q[BUF_W-1 -: 6];

  always_comb begin
    dec_sym = 4'd0;
    dec_len = 3'd1;
    casez (window)
      6'b1?????: begin dec_sym = 4'd0;  dec_len = 3'd1; end
      6'b0111??: begin dec_sym = 4'd9;  dec_len = 3'd4; end
      6'b0101??: begin dec_sym = 4'd2;  dec_len = 3'd4; end
      6'b0100??: begin dec_sym = 4'd1;  dec_len = 3'd4; end
      6'b0011??: begin dec_sym = 4'd6;  dec_len = 3'd4; end
      6'b0010??: begin dec_sym = 4'd5;  dec_len = 3'd4; end
      6'b0000??: begin dec_sym = 4'd10; dec_len = 3'd4; end
      6'b01101?: begin dec_sym = 4'd7;  dec_len = 3'd5; end
      6'b011000: begin dec_sym = 4'd3;  dec_len = 3'd6; end
      6'b011001: begin dec_sym = 4'd4;  dec_len = 3'd6; end
      6'b000110: begin dec_sym = 4'd8;  dec_len = 3'd6; end
      6'b000111: begin dec_sym = 4'd12; dec_len = 3'd6; end
      6'b000100: begin dec_sym = 4'd14; dec_len = 3'd6; end
      6'b000101: begin dec_sym = 4'd15; dec_len = 3'd6; end
      default:   begin dec_sym = 4'd0;  dec_len = 3'd1; end
    endcase
  end

  assign in_ready  = ((state_q == IDLE) || (state_q == RUN)) &&
                     (({1'b0, level_q} + (LW+1)'(IN_W)) <= (LW+1)'(BUF_W));
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign hs        = out_valid_q && out_ready;
  assign dec_ok    = slot_free &&
                     (((state_q == RUN) && (level_q >= LW'(6))) ||
                      ((state_q == DRAIN) && (level_q >= LW'(dec_len))));
  assign discard   = (state_q == DRAIN) && (level_q < LW'(dec_len));

  assign word_al   = {in_data, {(BUF_W-IN_W){1'b0}}};
  assign shifted   = dec_ok ? (buf_q << dec_len) : buf_q;
  assign lvl_after = dec_ok ? (level_q - LW'(dec_len)) : level_q;

  always_comb begin
    buf_d   = shifted;
    level_d = lvl_after;
    if (accept) begin
      buf_d   = shifted | (word_al >> lvl_after);
      level_d = lvl_after + LW'(IN_W);
    end
    if (discard) begin
      buf_d   = '0;
      level_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : RUN;
      RUN:     if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (discard && slot_free) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_sym_q   <= 4'd0;
      out_len_q   <= 3'd0;
    end else if (dec_ok) begin
      out_valid_q <= 1'b1;
      out_sym_q   <= dec_sym;
      out_len_q   <= dec_len;
    end else if (hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Statistics from a finished stream stay visible until the next stream's
  // first symbol is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'd0;
      trunc_q <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      if (state_q == DONE) fresh_q <= 1'b1;
      if (hs) begin
        if (fresh_q) begin
          count_q <= 16'd1;
          trunc_q <= 1'b0;
          fresh_q <= 1'b0;
        end else if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
      end
      if (discard && (|buf_q)) trunc_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_len   = out_len_q;
  assign buf_level = level_q;
  assign sym_count = count_q;
  assign trunc_err = trunc_q;
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_huffman_stream_decoder.sv
// Directed bench for huffman_stream_decoder: a code-table search model predicts
// symbols and end-of-stream statistics; a negedge monitor checks every output cycle.
module tb_huffman_stream_decoder;

  localparam int IN_W  = 8;
  localparam int BUF_W = 16;
  localparam int LW    = $clog2(BUF_W + 1);

  logic            clk;
  logic            rst;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [3:0]      out_sym;
  logic [2:0]      out_len;
  logic            out_valid;
  logic            out_ready;
  logic [LW-1:0]   buf_level;
  logic [15:0]     sym_count;
  logic            done;
  logic            trunc_err;
  logic [1:0]      dbg_state;

  huffman_stream_decoder #(.IN_W(IN_W), .BUF_W(BUF_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .out_sym(out_sym),
    .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready),
    .buf_level(buf_level), .sym_count(sym_count), .done(done),
    .trunc_err(trunc_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int max_lvl = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // code table: value of the code bits, code length, symbol
  int code_val [14] = '{1, 7, 5, 4, 3, 2, 0, 13, 24, 25, 6, 7, 4, 5};
  int code_len [14] = '{1, 4, 4, 4, 4, 4, 4, 5, 6, 6, 6, 6, 6, 6};
  int code_sym [14] = '{0, 9, 2, 1, 6, 5, 10, 7, 3, 4, 8, 12, 14, 15};

  logic [7:0]  stream_q[$];
  logic [6:0]  m_syms[$];
  bit          m_trunc;
  logic [6:0]  exp_q[$];
  logic [16:0] exp_done_q[$];

  task automatic model_run();
    int bits[$];
    int pos;
    int v;
    bit matched;
    m_syms.delete();
    m_trunc = 1'b0;
    foreach (stream_q[i])
      for (int b = 7; b >= 0; b--) bits.push_back(int'(stream_q[i][b]));
    pos = 0;
    forever begin
      matched = 1'b0;
      for (int k = 0; k < 14; k++) begin
        if (!matched && code_len[k] <= bits.size() - pos) begin
          v = 0;
          for (int j = 0; j < code_len[k]; j++) v = v * 2 + bits[pos + j];
          if (v == code_val[k]) begin
            matched = 1'b1;
            m_syms.push_back({3'(code_len[k]), 4'(code_sym[k])});
            pos += code_len[k];
          end
        end
      end
      if (!matched) break;
    end
    for (int j = pos; j < bits.size(); j++) if (bits[j] != 0) m_trunc = 1'b1;
  endtask

  // driver tasks
  task automatic send_word(input logic [7:0] w, input bit last);
    int n = 0;
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic play_stream();
    int start;
    int n;
    int cnt;
    model_run();
    foreach (m_syms[i]) exp_q.push_back(m_syms[i]);
    cnt = (m_syms.size() > 65535) ? 65535 : m_syms.size();
    exp_done_q.push_back({m_trunc, 16'(cnt)});
    start = done_cnt;
    foreach (stream_q[i]) send_word(stream_q[i], i == stream_q.size() - 1);
    n = 0;
    while (done_cnt == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // scoreboard / monitor
  logic       hold_pending = 1'b0;
  logic [6:0] held;
  logic       prev_done = 1'b0;
  logic [6:0] e;
  logic [16:0] d;

  always @(negedge clk) begin
    if (!rst) begin
      hold_pending <= 1'b0;
      prev_done    <= 1'b0;
    end else begin
      if (int'(buf_level) > max_lvl) max_lvl = int'(buf_level);
      check("buf_level_bound", int'(buf_level) <= BUF_W, 1);
      if (int'(buf_level) > BUF_W - IN_W) check("in_ready_full", int'(in_ready), 0);
      if (hold_pending) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_payload", int'({out_len, out_sym}), int'(held));
      end
      hold_pending <= out_valid && !out_ready;
      held         <= {out_len, out_sym};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_sym", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sym", int'(out_sym), int'(e[3:0]));
          check("len", int'(out_len), int'(e[6:4]));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", int'(prev_done), 0);
        check("missing_syms", exp_q.size(), 0);
        if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = exp_done_q.pop_front();
          check("trunc_err", int'(trunc_err), int'(d[16]));
          check("sym_count", int'(sym_count), int'(d[15:0]));
        end
      end
      prev_done <= done;
    end
  end

  initial begin
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_buf_level", int'(buf_level), 0);
    check("rst_out_sym", int'(out_sym), 0);
    check("rst_out_len", int'(out_len), 0);
    check("rst_sym_count", int'(sym_count), 0);
    check("rst_done", int'(done), 0);
    check("rst_trunc", int'(trunc_err), 0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // pin the model with hand-decoded streams
    stream_q = '{8'b1011_1011, 8'b0000_1101};
    model_run();
    check("model_a_n", m_syms.size(), 4);
    if (m_syms.size() == 4) begin
      check("model_a0", int'(m_syms[0]), int'({3'd1, 4'd0}));
      check("model_a1", int'(m_syms[1]), int'({3'd4, 4'd9}));
      check("model_a2", int'(m_syms[2]), int'({3'd6, 4'd3}));
      check("model_a3", int'(m_syms[3]), int'({3'd5, 4'd7}));
    end
    check("model_a_trunc", int'(m_trunc), 0);
    stream_q = '{8'b1111_1101};
    model_run();
    check("model_b_n", m_syms.size(), 6);
    check("model_b_trunc", int'(m_trunc), 1);

    @(posedge clk);
    #1;
    stream_q = '{8'b1011_1011, 8'b0000_1101};
    play_stream();
    stream_q = '{8'b1111_1101};
    play_stream();
    check("trunc_hold", int'(trunc_err), 1);
    check("count_hold", int'(sym_count), 6);
    stream_q = '{8'b0000_0000};
    play_stream();

    // throughput: 3 all-ones words
    stream_q = '{8'hFF, 8'hFF, 8'hFF};
    fork
      play_stream();
      begin
        int n = 0;
        int run = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        while (out_valid && run < 100) begin run++; @(negedge clk); end
        check("tput_run", run, 24);
      end
    join

    // backpressure mid-stream
    max_lvl = 0;
    stream_q = '{8'hB5, 8'h3C, 8'h99, 8'h0E};
    fork
      play_stream();
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("bp_fill", int'(max_lvl > BUF_W - IN_W), 1);

    // latency then reset with a pending symbol
    out_ready = 1'b0;
    send_word(8'b1011_1011, 1'b0);
    check("lat_e0_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_e1_valid", int'(out_valid), 1);
    check("lat_e1_sym", int'(out_sym), 0);
    check("lat_e1_level", int'(buf_level), 7);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_level", int'(buf_level), 0);
    check("mid_rst_count", int'(sym_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", int'(in_ready), 1);
    stream_q = '{8'b1011_1011, 8'b0000_1101};
    play_stream();

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/huffman_stream_decoder.md
HUFFMAN_STREAM_DECODER -- requirements
Module: huffman_stream_decoder

Interface
REQ-001 SHALL have parameter IN_W, default 8, input word width in bits (legal 6..16).
REQ-002 SHALL have parameter BUF_W, default 2*IN_W, bit-buffer capacity (legal BUF_W >= IN_W+6).
REQ-003 SHALL have ports: clk input 1 clock; rst input 1 reset, asynchronous, active-low.
REQ-004 SHALL have in_data input IN_W: encoded bits, MSB first in stream order.
REQ-005 SHALL have in_valid input 1, in_ready output 1, in_last input 1 (word is final word of stream).
REQ-006 SHALL have out_sym output 4 (decoded symbol) and out_len output 3 (code length 1..6).
REQ-007 SHALL have out_valid output 1 and out_ready input 1.
REQ-008 SHALL have buf_level output $clog2(BUF_W+1): valid bits held.
REQ-009 SHALL have sym_count output 16 (symbols emitted in current stream), done output 1 (end-of-stream pulse), trunc_err output 1 (nonzero residual discarded).

Function
REQ-010 SHALL decode a fixed prefix code, MSB first: 1->0; 0111->9; 0101->2; 0100->1; 0011->6; 0010->5; 0000->10; 01101->7; 011000->3; 011001->4; 000110->8; 000111->12; 000100->14; 000101->15.
REQ-011 Code is complete (Kraft sum 1); every 6-bit window SHALL decode; no invalid-code path.
REQ-012 Input handshake: word accepted on edge with in_valid && in_ready; appended below existing buffered bits.
REQ-013 in_ready SHALL be 1 only in IDLE/RUN and when buf_level + IN_W <= BUF_W (same-cycle consumption not credited).
REQ-014 Decode SHALL occur when output register empty or handshaking this cycle, and buf_level >= 6 (RUN) or buf_level >= decoded length (DRAIN).
REQ-015 Decode SHALL load out_sym/out_len, set out_valid, remove length bits from buffer head; max one symbol per cycle.
REQ-016 out_valid/out_sym/out_len SHALL hold stable until out_valid && out_ready.
REQ-017 Latency: word accepted on edge E0 with buffer empty -> out_valid high after edge E1.
REQ-018 Simultaneous accept and decode SHALL give buf_level' = buf_level + IN_W - len.
REQ-019 FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on first accepted word; any state except DONE -> DRAIN when word with in_last accepted.
REQ-021 DRAIN: decode while a complete code remains; when remaining bits < next code length (incl. 0), discard them, set trunc_err=1 if any discarded bit is 1, go DONE once output register empty.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; trunc_err and sym_count hold until first symbol of next stream, then trunc_err clears and sym_count restarts at 1.
REQ-023 sym_count SHALL increment on each output handshake, saturating at 16'hFFFF.
REQ-024 Zero-pad residual (all-zero, <4 bits) SHALL be discarded silently.

Reset
REQ-025 On rst low, immediately: state IDLE, buffer cleared, buf_level 0, out_valid 0, out_sym 0, out_len 0, sym_count 0, done 0, trunc_err 0; in_ready 1 after release.
REQ-026 Reset mid-stream SHALL discard all buffered bits and any pending output symbol without emitting it.

Verification
REQ-027 IN_W=8: words 8'b1011_1011, 8'b0000_1101 (in_last) with out_ready=1 -> symbols 0,9,3,7 with lengths 1,4,6,5; done pulse; trunc_err=0; sym_count=4.
REQ-028 Single word 8'b1111_1101 in_last -> six symbols 0; residual "01" discarded; trunc_err=1; sym_count=6.
REQ-029 Backpressure: out_ready low 5 cycles mid-stream -> out_sym stable, in_ready low once buf_level > BUF_W-IN_W, no symbol lost or duplicated after release.
REQ-030 Throughput: continuous 8'hFF words, out_ready=1 -> one symbol 0 per cycle, buf_level never exceeds BUF_W, N words -> sym_count=8N.
REQ-031 rst asserted while out_valid=1 and buf_level>0 -> out_valid=0, buf_level=0 same cycle; subsequent stream from REQ-027 decodes correctly.
REQ-032 Word 8'b0000_0000 in_last -> symbols 10,10; no residual; trunc_err=0; done pulse.
